sti_dac_gen: RTL and testbench

- Parametrised serial-transmit and data-arrange block.
- Accepts parallel words with a handshake and builds frames of configurable length and alignment.
- Shifts each frame out serially, MSB- or LSB-first.
- Packs the same bit stream into PIX_W-bit pixels written to a pixel memory.
- On end-of-stream it flushes any partial pixel, zero-fills the remaining memory, then raises finish.

---
 rtl/sti_dac_gen_if.sv | 35 +++
 rtl/sti_dac_gen.sv | 182 ++++++++++++++++++
 tb/tb_sti_dac_gen.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/sti_dac_gen_if.sv
// Parallel-word handshake, serial output and pixel-memory write bundle for sti_dac_gen.
// The master drives words in; the slave (the generator) drives the serial and pixel outputs.
interface sti_dac_gen_if #(
  parameter int DW     = 16,
  parameter int NSEG   = 4,
  parameter int PIX_W  = 8,
  parameter int ADDR_W = 8
);
  localparam int LEN_W = (NSEG > 1) ? $clog2(NSEG) : 1;

  logic              load;
  logic              pi_ready;
  logic [DW-1:0]     pi_data;
  logic [LEN_W-1:0]  pi_length;
  logic              pi_fill;
  logic              pi_msb;
  logic              pi_low;
  logic              pi_end;
  logic              so_data;
  logic              so_valid;
  logic              pixel_wr;
  logic [ADDR_W-1:0] pixel_addr;
  logic [PIX_W-1:0]  pixel_dataout;
  logic              pixel_finish;

  modport master (
    output load, pi_data, pi_length, pi_fill, pi_msb, pi_low, pi_end,
    input  pi_ready, so_data, so_valid, pixel_wr, pixel_addr, pixel_dataout, pixel_finish
  );

  modport slave (
    input  load, pi_data, pi_length, pi_fill, pi_msb, pi_low, pi_end,
    output pi_ready, so_data, so_valid, pixel_wr, pixel_addr, pixel_dataout, pixel_finish
  );
endinterface

// File: rtl/sti_dac_gen.sv
// Serial-transmit and data-arrange block: builds frames from parallel words, shifts them out
// serially and packs the same bit stream into pixels, then flushes and zero-fills the memory.
module sti_dac_gen #(
  parameter int DW     = 16,
  parameter int SEG_W  = 8,
  parameter int NSEG   = 4,
  parameter int PIX_W  = 8,
  parameter int ADDR_W = 8
) (
  input logic          clk,
  input logic          reset,
  sti_dac_gen_if.slave bus
);
  localparam int FL = NSEG * SEG_W;
  localparam int CW = $clog2(FL + 1);
  localparam int KW = $clog2(PIX_W + 1);
  localparam logic [ADDR_W-1:0] ADDR_MAX = {ADDR_W{1'b1}};

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SHIFT = 3'd1,
    S_FLUSH = 3'd2,
    S_FILL  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  function automatic logic [FL-1:0] f_rev(input logic [FL-1:0] x);
    logic [FL-1:0] y;
    for (int i = 0; i < FL; i++) y[i] = x[FL-1-i];
    return y;
  endfunction

  state_t            r_state, w_next;
  logic [FL-1:0]     r_sr;
  logic [CW-1:0]     r_bits_left;
  logic              r_end;
  logic              r_so_data, r_so_valid, r_pi_ready;
  logic [PIX_W-1:0]  r_acc;
  logic [KW-1:0]     r_acc_cnt;
  logic              r_pixel_wr, r_finish;
  logic [ADDR_W-1:0] r_pixel_addr;
  logic [PIX_W-1:0]  r_pixel_data;

  logic [CW-1:0]     w_len;
  logic [FL-1:0]     w_data_ext, w_frame, w_sr_init;
  logic [PIX_W-1:0]  w_acc_next, w_wr_data;
  logic [ADDR_W-1:0] w_wr_addr;
  logic              w_accept, w_last, w_pix_done, w_full, w_hits_max, w_wr_en;

  assign w_len      = CW'((32'(bus.pi_length) + 32'd1) * 32'(SEG_W));
  assign w_data_ext = FL'(bus.pi_data);
  assign w_accept   = bus.load && r_pi_ready && (r_state == S_IDLE);
  assign w_last     = (r_state == S_SHIFT) && (r_bits_left == '0);
  assign w_acc_next = {r_acc[PIX_W-2:0], r_so_data};
  assign w_pix_done = r_so_valid && (r_acc_cnt == KW'(PIX_W - 1));
  // Memory is full once the write to the last address is on the bus or already done.
  assign w_full     = r_finish || (r_pixel_wr && (r_pixel_addr == ADDR_MAX));
  assign w_wr_addr  = r_pixel_wr ? (r_pixel_addr + ADDR_W'(1)) : r_pixel_addr;
  assign w_hits_max = w_pix_done && !w_full && (w_wr_addr == ADDR_MAX);

  // Frame build from the word being accepted, then normalised so the next bit is always the MSB.
  always_comb begin
    w_frame = w_data_ext;
    if (w_len < CW'(DW)) begin
      if (bus.pi_low) w_frame = w_data_ext & ({FL{1'b1}} >> (CW'(FL) - w_len));
      else            w_frame = w_data_ext >> (CW'(DW) - w_len);
    end else if (w_len > CW'(DW)) begin
      if (bus.pi_fill) w_frame = w_data_ext << (w_len - CW'(DW));
      else             w_frame = w_data_ext;
    end else begin
      w_frame = w_data_ext;
    end
    if (bus.pi_msb) w_sr_init = w_frame << (CW'(FL) - w_len);
    else            w_sr_init = f_rev(w_frame);
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Next-state logic.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_full)        w_next = S_DONE;
        else if (w_accept) w_next = S_SHIFT;
        else               w_next = S_IDLE;
      end
      S_SHIFT: begin
        if (!w_last)     w_next = S_SHIFT;
        else if (w_full) w_next = S_DONE;
        else if (r_end)  w_next = S_FLUSH;
        else             w_next = S_IDLE;
      end
      S_FLUSH: w_next = w_full ? S_DONE : S_FILL;
      S_FILL:  w_next = w_full ? S_DONE : S_FILL;
      S_DONE:  w_next = S_DONE;
      default: w_next = S_IDLE;
    endcase
  end

  // Pixel write selection: partial flush, zero fill, or a freshly packed pixel.
  always_comb begin
    w_wr_en   = 1'b0;
    w_wr_data = '0;
    case (r_state)
      S_FLUSH: begin
        w_wr_en   = (r_acc_cnt != '0) && !w_full;
        w_wr_data = r_acc << (KW'(PIX_W) - r_acc_cnt);
      end
      S_FILL: begin
        w_wr_en   = !w_full;
        w_wr_data = '0;
      end
      default: begin
        w_wr_en   = w_pix_done && !w_full;
        w_wr_data = w_acc_next;
      end
    endcase
  end

  // Serial shifter, pixel accumulator and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sr         <= '0;
      r_bits_left  <= '0;
      r_end        <= 1'b0;
      r_so_data    <= 1'b0;
      r_so_valid   <= 1'b0;
      r_pi_ready   <= 1'b1;
      r_acc        <= '0;
      r_acc_cnt    <= '0;
      r_pixel_wr   <= 1'b0;
      r_pixel_addr <= '0;
      r_pixel_data <= '0;
      r_finish     <= 1'b0;
    end else begin
      // A pixel completing on a frame's last bit lands on the last address: hold off new words.
      r_pi_ready <= (w_next == S_IDLE) && !w_hits_max;

      if (w_accept) begin
        r_so_valid  <= 1'b1;
        r_so_data   <= w_sr_init[FL-1];
        r_sr        <= w_sr_init << 1;
        r_bits_left <= w_len - CW'(1);
        r_end       <= bus.pi_end;
      end else if ((r_state == S_SHIFT) && !w_last) begin
        r_so_valid  <= 1'b1;
        r_so_data   <= r_sr[FL-1];
        r_sr        <= r_sr << 1;
        r_bits_left <= r_bits_left - CW'(1);
      end else begin
        r_so_valid <= 1'b0;
        r_so_data  <= 1'b0;
      end

      if (r_state == S_FLUSH) begin
        r_acc     <= '0;
        r_acc_cnt <= '0;
      end else if (r_so_valid) begin
        r_acc     <= w_acc_next;
        r_acc_cnt <= w_pix_done ? '0 : (r_acc_cnt + KW'(1));
      end

      r_pixel_wr   <= w_wr_en;
      r_pixel_data <= w_wr_en ? w_wr_data : '0;
      if (r_pixel_wr && (r_pixel_addr != ADDR_MAX)) r_pixel_addr <= r_pixel_addr + ADDR_W'(1);
      r_finish <= w_full;
    end
  end

  assign bus.pi_ready      = r_pi_ready;
  assign bus.so_data       = r_so_data;
  assign bus.so_valid      = r_so_valid;
  assign bus.pixel_wr      = r_pixel_wr;
  assign bus.pixel_addr    = r_pixel_addr;
  assign bus.pixel_dataout = r_pixel_data;
  assign bus.pixel_finish  = r_finish;
endmodule

// File: tb/tb_sti_dac_gen.sv
// Scoreboard bench for sti_dac_gen: a bit-stream reference model feeds expected serial bits and
// pixel writes into queues; a negedge monitor pops and compares whatever the DUT presents.
module tb_sti_dac_gen;
  localparam int DW     = 16;
  localparam int SEG_W  = 4;
  localparam int NSEG   = 8;
  localparam int PIX_W  = 8;
  localparam int ADDR_W = 8;
  localparam int LEN_W  = 3;
  localparam int FL     = NSEG * SEG_W;
  localparam int DEPTH  = 1 << ADDR_W;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  sti_dac_gen_if #(.DW(DW), .NSEG(NSEG), .PIX_W(PIX_W), .ADDR_W(ADDR_W)) bus ();

  sti_dac_gen #(.DW(DW), .SEG_W(SEG_W), .NSEG(NSEG), .PIX_W(PIX_W), .ADDR_W(ADDR_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;
  bit mon_en = 1'b0;
  bit prev_max = 1'b0;
  bit exp_so[$];
  int exp_addr[$];
  int exp_pix[$];
  int m_nbits, m_pix, m_addr;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: the serial stream is a list of bits; every PIX_W bits make one pixel.
  function automatic void m_bit(input bit b);
    exp_so.push_back(b);
    if (m_addr < DEPTH) begin
      m_pix = (m_pix * 2 + int'(b)) % (1 << PIX_W);
      m_nbits++;
      if (m_nbits == PIX_W) begin
        exp_addr.push_back(m_addr);
        exp_pix.push_back(m_pix);
        m_addr++;
        m_nbits = 0;
        m_pix = 0;
      end
    end
  endfunction

  function automatic void m_frame(input int data, input int len, input int fill, input int msb, input int low);
    int L = (len + 1) * SEG_W;
    logic [63:0] fr;
    fr = 64'(data);
    if (L < DW) fr = (low != 0) ? 64'(data % (1 << L)) : 64'(data >> (DW - L));
    else if (L > DW && fill != 0) fr = 64'(data) * 64'(1 << (L - DW));
    for (int i = 0; i < L; i++) m_bit((msb != 0) ? fr[L-1-i] : fr[i]);
  endfunction

  function automatic void m_end();
    if (m_addr < DEPTH && m_nbits > 0) begin
      exp_addr.push_back(m_addr);
      exp_pix.push_back((m_pix * (1 << (PIX_W - m_nbits))) % (1 << PIX_W));
      m_addr++;
    end
    while (m_addr < DEPTH) begin
      exp_addr.push_back(m_addr);
      exp_pix.push_back(0);
      m_addr++;
    end
  endfunction

  // Monitor: compares every presented serial bit and pixel write against the queues.
  always @(negedge clk) begin
    if (mon_en) begin
      if (bus.so_valid === 1'b1) begin
        if (exp_so.size() == 0) begin
          errors++;
          $display("FAIL so_unexpected: serial bit %0b presented, none expected (t=%0t)", bus.so_data, $time);
        end else chk("so_data", 64'(bus.so_data), 64'(exp_so.pop_front()));
      end else chk("so_data_idle", 64'(bus.so_data), 64'd0);
      if (prev_max) begin
        chk("finish_after_last_write", 64'(bus.pixel_finish), 64'd1);
        chk("no_write_after_last", 64'(bus.pixel_wr), 64'd0);
      end
      if (bus.pixel_wr === 1'b1) begin
        if (exp_addr.size() == 0) begin
          errors++;
          $display("FAIL pixel_unexpected: write addr %0h data %0h, none expected (t=%0t)",
                   bus.pixel_addr, bus.pixel_dataout, $time);
        end else begin
          chk("pixel_addr", 64'(bus.pixel_addr), 64'(exp_addr.pop_front()));
          chk("pixel_data", 64'(bus.pixel_dataout), 64'(exp_pix.pop_front()));
        end
      end
      prev_max = (bus.pixel_wr === 1'b1) && (bus.pixel_addr == ADDR_W'(DEPTH - 1));
    end
  end

  task automatic scramble();
    bus.pi_data   = DW'($urandom);
    bus.pi_length = LEN_W'($urandom);
    bus.pi_fill   = 1'($urandom);
    bus.pi_msb    = 1'($urandom);
    bus.pi_low    = 1'($urandom);
    bus.pi_end    = 1'($urandom);
  endtask

  task automatic do_reset();
    mon_en = 1'b0;
    reset = 1'b1;
    bus.load = 1'b0;
    @(posedge clk); #1;
    chk("rst_so_valid", 64'(bus.so_valid), 64'd0);
    chk("rst_so_data", 64'(bus.so_data), 64'd0);
    chk("rst_pixel_wr", 64'(bus.pixel_wr), 64'd0);
    chk("rst_pixel_addr", 64'(bus.pixel_addr), 64'd0);
    chk("rst_pixel_dataout", 64'(bus.pixel_dataout), 64'd0);
    chk("rst_pixel_finish", 64'(bus.pixel_finish), 64'd0);
    chk("rst_pi_ready", 64'(bus.pi_ready), 64'd1);
    exp_so.delete();
    exp_addr.delete();
    exp_pix.delete();
    m_nbits = 0;
    m_pix = 0;
    m_addr = 0;
    prev_max = 1'b0;
    reset = 1'b0;
    mon_en = 1'b1;
  endtask

  // Handshake one word; returns #1 after the accepting edge with load still high.
  task automatic start_frame(input int data, input int len, input int fill, input int msb,
                             input int low, input int endf, output bit ok);
    int n = 0;
    while (bus.pi_ready !== 1'b1 && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    if (bus.pi_ready !== 1'b1) begin
      errors++;
      $display("FAIL ready_timeout: pi_ready=%b after %0d cycles, expected 1", bus.pi_ready, n);
      ok = 1'b0;
      return;
    end
    bus.load      = 1'b1;
    bus.pi_data   = DW'(data);
    bus.pi_length = LEN_W'(len);
    bus.pi_fill   = 1'(fill);
    bus.pi_msb    = 1'(msb);
    bus.pi_low    = 1'(low);
    bus.pi_end    = 1'(endf);
    m_frame(data % (1 << DW), len, fill, msb, low);
    if (endf != 0) m_end();
    @(posedge clk); #1;
    ok = 1'b1;
  endtask

  task automatic send(input int data, input int len, input int fill, input int msb,
                      input int low, input int endf, input bit hold);
    bit ok;
    int cnt;
    int L = (len + 1) * SEG_W;
    start_frame(data, len, fill, msb, low, endf, ok);
    if (!ok) return;
    if (!hold) begin
      bus.load = 1'b0;
      scramble();
    end
    if (endf == 0 && m_addr < DEPTH) begin
      chk("ready_low_after_accept", 64'(bus.pi_ready), 64'd0);
      cnt = 0;
      while (bus.pi_ready !== 1'b1 && cnt < 200) begin
        @(posedge clk); #1;
        cnt++;
      end
      bus.load = 1'b0;
      chk("ready_return_cycles", 64'(cnt), 64'(L));
    end else begin
      cnt = 0;
      while (bus.pixel_finish !== 1'b1 && cnt < 3000) begin
        @(posedge clk); #1;
        cnt++;
      end
      chk("finish_reached", 64'(bus.pixel_finish), 64'd1);
      bus.load = 1'b0;
      repeat (FL + 4) @(posedge clk);
      #1;
      chk("ready_low_in_done", 64'(bus.pi_ready), 64'd0);
      chk("finish_sticky", 64'(bus.pixel_finish), 64'd1);
    end
  endtask

  task automatic drain_check();
    repeat (4) @(posedge clk);
    #1;
    chk("so_queue_drained", 64'(exp_so.size()), 64'd0);
    chk("pixel_queue_drained", 64'(exp_addr.size()), 64'd0);
  endtask

  initial begin
    bit ok;
    int guard;
    bus.load = 1'b0;
    scramble();
    do_reset();

    // Directed words: MSB-first 16-bit, LSB-first high byte, 24-bit fill both ways.
    send(16'hA5C3, 3, 0, 1, 0, 0, 1'b0);
    send(16'h12F0, 1, 0, 0, 0, 0, 1'b0);
    send(16'hFFFF, 5, 1, 1, 0, 0, 1'b0);
    send(16'hFFFF, 5, 0, 1, 0, 0, 1'b0);
    drain_check();

    // load held high through the whole frame: exactly one frame.
    send(int'($urandom_range(0, 65535)), 3, 0, 1, 0, 0, 1'b1);
    drain_check();

    // Reset in the middle of a frame, then restart from pixel address 0.
    start_frame(16'hBEEF, 3, 0, 1, 0, 0, ok);
    bus.load = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    do_reset();
    send(16'h8001, 3, 0, 1, 0, 0, 1'b0);
    drain_check();

    // 12-bit stream ending the run: partial flush then zero fill.
    do_reset();
    send(16'h0ABC, 2, 0, 1, 1, 1, 1'b0);
    drain_check();

    // Random stream ending with pi_end.
    do_reset();
    for (int i = 0; i < 40; i++)
      send(int'($urandom_range(0, 65535)), int'($urandom_range(0, 7)), int'($urandom_range(0, 1)),
           int'($urandom_range(0, 1)), int'($urandom_range(0, 1)), (i == 39) ? 1 : 0, 1'b0);
    drain_check();

    // Random stream overrunning the memory without pi_end.
    do_reset();
    guard = 0;
    while (m_addr < DEPTH && guard < 400) begin
      send(int'($urandom_range(0, 65535)), int'($urandom_range(0, 7)), int'($urandom_range(0, 1)),
           int'($urandom_range(0, 1)), int'($urandom_range(0, 1)), 0, 1'b0);
      guard++;
    end
    drain_check();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL global_timeout: simulation did not complete, %0d checks, %0d errors", checks, errors);
    $fatal(1, "timeout");
  end
endmodule
